// File: rtl/coreabc_ramfifo_ctrl_if.sv
// Handshake, status and RAM-wrapper signals of the RAM-backed FIFO controller.
// The master side drives the push/pop requests and returns RAM read data.
interface coreabc_ramfifo_ctrl_if;
  logic        CLEAR;
  logic        WR_VALID;
  logic [15:0] WR_DATA;
  logic        WR_READY;
  logic        RD_VALID;
  logic [15:0] RD_DATA;
  logic        RD_READY;
  logic [8:0]  COUNT;
  logic        FULL;
  logic        EMPTY;
  logic        ALMOST_FULL;
  logic        RAM_WEN;
  logic        RAM_REN;
  logic [7:0]  RAM_WADDR;
  logic [7:0]  RAM_RADDR;
  logic [15:0] RAM_WD;
  logic [15:0] RAM_RD;

  modport master (
    output CLEAR, WR_VALID, WR_DATA, RD_READY, RAM_RD,
    input  WR_READY, RD_VALID, RD_DATA, COUNT, FULL, EMPTY, ALMOST_FULL,
           RAM_WEN, RAM_REN, RAM_WADDR, RAM_RADDR, RAM_WD
  );

  modport slave (
    input  CLEAR, WR_VALID, WR_DATA, RD_READY, RAM_RD,
    output WR_READY, RD_VALID, RD_DATA, COUNT, FULL, EMPTY, ALMOST_FULL,
           RAM_WEN, RAM_REN, RAM_WADDR, RAM_RADDR, RAM_WD
  );
endinterface

// File: rtl/coreabc_ramfifo_ctrl.sv
// FIFO controller around an external 256x16 synchronous-read RAM, with a
// two-entry registered skid stage in front of RD_DATA.
//
// state      | meaning
// SKID_EMPTY | no word held in the output stage
// SKID_ONE   | head slot holds the next word out
// SKID_TWO   | head and second slot both hold words
module coreabc_ramfifo_ctrl #(
  parameter int unsigned AFULL_LEVEL = 192
) (
  input  logic                   PCLK,
  input  logic                   PRESETN,
  coreabc_ramfifo_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  skid_state_t skid_state;
  skid_state_t skid_next;

  logic [7:0]  wptr;
  logic [7:0]  rptr;
  logic [8:0]  ram_occ;
  logic [8:0]  count;
  logic        in_flight;
  logic [15:0] slot0;
  logic [15:0] slot1;
  logic [15:0] slot0_next;
  logic [15:0] slot1_next;

  logic        ram_has_room;
  logic        wr_ready;
  logic        head_valid;
  logic        tail_valid;
  logic        push;
  logic        pop;
  logic        rd_issue;
  logic [1:0]  pending;

  assign head_valid   = (skid_state != SKID_EMPTY);
  assign tail_valid   = (skid_state == SKID_TWO);
  assign ram_has_room = (ram_occ != 9'd256);

  // Gated by PRESETN so the push side is closed for the whole reset interval.
  assign wr_ready = PRESETN & ram_has_room & ~bus.CLEAR;
  assign push     = bus.WR_VALID & wr_ready;
  assign pop      = head_valid & bus.RD_READY;

  // Words already committed to the output stage, including a read in flight.
  assign pending  = {1'b0, head_valid} + {1'b0, tail_valid} + {1'b0, in_flight};

  // Occupancy >= 1 keeps the read address away from a live write address.
  assign rd_issue = ~bus.CLEAR & (ram_occ != 9'd0) & (pending <= (2'd1 + {1'b0, pop}));

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_occ   <= '0;
      count     <= '0;
      in_flight <= 1'b0;
    end else if (bus.CLEAR) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_occ   <= '0;
      count     <= '0;
      in_flight <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 8'd1;
      end
      if (rd_issue) begin
        rptr <= rptr + 8'd1;
      end
      ram_occ   <= ram_occ + {8'd0, push} - {8'd0, rd_issue};
      count     <= count + {8'd0, push} - {8'd0, pop};
      in_flight <= rd_issue;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      skid_state <= SKID_EMPTY;
      slot0      <= '0;
      slot1      <= '0;
    end else begin
      skid_state <= skid_next;
      slot0      <= slot0_next;
      slot1      <= slot1_next;
    end
  end

  always_comb begin
    skid_next  = skid_state;
    slot0_next = slot0;
    slot1_next = slot1;
    case (skid_state)
      SKID_EMPTY: begin
        if (in_flight) begin
          slot0_next = bus.RAM_RD;
          skid_next  = SKID_ONE;
        end
      end
      SKID_ONE: begin
        case ({pop, in_flight})
          2'b01: begin
            slot1_next = bus.RAM_RD;
            skid_next  = SKID_TWO;
          end
          2'b10: begin
            skid_next  = SKID_EMPTY;
          end
          2'b11: begin
            slot0_next = bus.RAM_RD;
          end
          default: begin
            skid_next  = SKID_ONE;
          end
        endcase
      end
      SKID_TWO: begin
        if (pop) begin
          slot0_next = slot1;
          if (in_flight) begin
            slot1_next = bus.RAM_RD;
          end else begin
            skid_next  = SKID_ONE;
          end
        end
      end
      default: begin
        skid_next = SKID_EMPTY;
      end
    endcase
    // Flush wins over any capture or pop in the same cycle.
    if (bus.CLEAR) begin
      skid_next  = SKID_EMPTY;
      slot0_next = '0;
      slot1_next = '0;
    end
  end

  assign bus.WR_READY    = wr_ready;
  assign bus.RD_VALID    = head_valid;
  assign bus.RD_DATA     = slot0;
  assign bus.COUNT       = count;
  assign bus.FULL        = ~ram_has_room;
  assign bus.EMPTY       = (count == 9'd0);
  assign bus.ALMOST_FULL = (ram_occ >= 9'(AFULL_LEVEL));
  assign bus.RAM_WEN     = push;
  assign bus.RAM_WADDR   = wptr;
  assign bus.RAM_WD      = bus.WR_DATA;
  assign bus.RAM_REN     = rd_issue;
  assign bus.RAM_RADDR   = rptr;

endmodule

// File: tb/tb_coreabc_ramfifo_ctrl.sv
// Directed and random bench for coreabc_ramfifo_ctrl with a behavioural RAM
// and a queue scoreboard of words expected at RD_DATA.
module tb_coreabc_ramfifo_ctrl;
  localparam int AFL = 192;

  logic pclk;
  logic presetn;

  coreabc_ramfifo_ctrl_if bus ();

  coreabc_ramfifo_ctrl #(.AFULL_LEVEL(AFL)) dut (
    .PCLK    (pclk),
    .PRESETN (presetn),
    .bus     (bus)
  );

  logic [15:0] mem [256];
  logic [15:0] exp_q [$];
  int checks = 0;
  int passed = 0;
  int model_count = 0;
  int cyc = 0;
  int first_pop = -1;
  int last_pop = -1;
  int npop = 0;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) begin
    if (bus.RAM_WEN) mem[bus.RAM_WADDR] <= bus.RAM_WD;
    if (bus.RAM_REN) bus.RAM_RD <= mem[bus.RAM_RADDR];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
  endtask

  // One clock cycle with the currently driven inputs; scoreboard updated at the edge.
  task automatic step();
    logic do_push;
    logic do_pop;
    #1;
    do_push = bus.WR_VALID && bus.WR_READY;
    do_pop  = bus.RD_VALID && bus.RD_READY && !bus.CLEAR;
    if (bus.RD_VALID) begin
      check("rd_valid_has_data", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("rd_data", bus.RD_DATA, exp_q[0]);
    end
    if (bus.RAM_WEN && bus.RAM_REN) check("same_addr_rw", bus.RAM_WADDR == bus.RAM_RADDR, 1'b0);
    if (bus.CLEAR) begin
      exp_q.delete();
      model_count = 0;
    end else begin
      if (do_pop) begin
        void'(exp_q.pop_front());
        model_count--;
        npop++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (do_push) begin
        exp_q.push_back(bus.WR_DATA);
        model_count++;
      end
    end
    @(posedge pclk);
    cyc++;
    #1;
    check("count", 32'(bus.COUNT), model_count);
    check("empty", bus.EMPTY, model_count == 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_valid", bus.RD_VALID, 1'b0);
    check("rst_wr_ready", bus.WR_READY, 1'b0);
    check("rst_empty", bus.EMPTY, 1'b1);
    check("rst_full", bus.FULL, 1'b0);
    check("rst_almost_full", bus.ALMOST_FULL, 1'b0);
    check("rst_ram_wen", bus.RAM_WEN, 1'b0);
    check("rst_ram_ren", bus.RAM_REN, 1'b0);
    check("rst_rd_data", bus.RD_DATA, 16'h0000);
    check("rst_count", 32'(bus.COUNT), 0);
  endtask

  task automatic drain(input int budget);
    bus.WR_VALID = 1'b0;
    bus.RD_READY = 1'b1;
    for (int b = 0; b < budget && exp_q.size() > 0; b++) step();
    check("drain_done", exp_q.size(), 0);
    bus.RD_READY = 1'b0;
    step();
    check("drain_rd_valid", bus.RD_VALID, 1'b0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    presetn      = 1'b0;
    bus.CLEAR    = 1'b0;
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 16'hDEAD;
    bus.RD_READY = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check_reset_outputs();

    // Release reset and check the push side opens.
    bus.WR_VALID = 1'b0;
    bus.RD_READY = 1'b0;
    presetn      = 1'b1;
    step();
    check("wr_ready_after_reset", bus.WR_READY, 1'b1);

    // Single push into an empty FIFO: two-edge first-word latency.
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 16'h1234;
    step();
    bus.WR_VALID = 1'b0;
    check("lat_rd_valid_n", bus.RD_VALID, 1'b0);
    #1;
    check("lat_ram_ren", bus.RAM_REN, 1'b1);
    check("lat_ram_raddr", bus.RAM_RADDR, 8'd0);
    step();
    check("lat_rd_valid_n1", bus.RD_VALID, 1'b0);
    step();
    check("lat_rd_valid_n2", bus.RD_VALID, 1'b1);
    check("lat_rd_data", bus.RD_DATA, 16'h1234);
    check("lat_count", 32'(bus.COUNT), 1);
    check("lat_empty", bus.EMPTY, 1'b0);
    drain(10);

    // Fill to full with the reader stalled.
    for (int k = 1; k <= 260; k++) begin
      bus.WR_VALID = 1'b1;
      bus.WR_DATA  = 16'(k - 1);
      step();
      check("fill_almost_full", bus.ALMOST_FULL, k >= AFL + 2);
      check("fill_full", bus.FULL, k >= 258);
      check("fill_wr_ready", bus.WR_READY, k < 258);
    end
    check("fill_count", 32'(bus.COUNT), 258);
    check("fill_head", bus.RD_DATA, 16'h0000);
    drain(600);

    // Streaming push and pop through two pointer wraps.
    first_pop = -1;
    last_pop  = -1;
    npop      = 0;
    bus.RD_READY = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bus.WR_VALID = 1'b1;
      bus.WR_DATA  = 16'(i * 7 + 3);
      step();
      if (i == 300) check("stream_steady_count", 32'(bus.COUNT), 3);
    end
    drain(20);
    check("stream_words_out", npop, 600);
    check("stream_span", last_pop - first_pop + 1, 600);

    // Flush in the same cycle as a read issue, a push and an in-flight read.
    bus.RD_READY = 1'b0;
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 16'h1111;
    step();
    bus.WR_DATA  = 16'h2222;
    step();
    bus.CLEAR    = 1'b1;
    bus.WR_DATA  = 16'h3333;
    #1;
    check("clr_wr_ready", bus.WR_READY, 1'b0);
    check("clr_ram_wen", bus.RAM_WEN, 1'b0);
    check("clr_ram_ren", bus.RAM_REN, 1'b0);
    step();
    bus.CLEAR    = 1'b0;
    bus.WR_VALID = 1'b0;
    check("clr_count", 32'(bus.COUNT), 0);
    check("clr_empty", bus.EMPTY, 1'b1);
    check("clr_rd_valid", bus.RD_VALID, 1'b0);
    step();
    check("clr_inflight_dropped", bus.RD_VALID, 1'b0);
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 16'hBEEF;
    step();
    bus.WR_VALID = 1'b0;
    step();
    step();
    check("clr_first_valid", bus.RD_VALID, 1'b1);
    check("clr_first_data", bus.RD_DATA, 16'hBEEF);
    drain(10);

    // Random backpressure: fill-biased half, then drain-biased half.
    for (int c = 0; c < 10000; c++) begin
      if (c < 5000) begin
        bus.WR_VALID = ($urandom_range(3) != 0);
        bus.RD_READY = ($urandom_range(3) == 0);
      end else begin
        bus.WR_VALID = ($urandom_range(3) == 0);
        bus.RD_READY = ($urandom_range(3) != 0);
      end
      bus.WR_DATA = 16'($urandom);
      step();
    end
    drain(1000);

    // Asynchronous reset in the middle of a stream.
    bus.RD_READY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.WR_VALID = 1'b1;
      bus.WR_DATA  = 16'hC000 + 16'(i);
      step();
    end
    #2;
    presetn = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    model_count = 0;
    bus.WR_VALID = 1'b0;
    bus.RD_READY = 1'b0;
    @(posedge pclk);
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    step();
    check("post_rst_rd_valid", bus.RD_VALID, 1'b0);
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 16'h5A5A;
    step();
    bus.WR_VALID = 1'b0;
    step();
    step();
    check("post_rst_first_data", bus.RD_DATA, 16'h5A5A);
    drain(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/coreabc_ramfifo_ctrl.md
COREABC_RAMFIFO_CTRL -- requirements
Module: coreabc_ramfifo_ctrl

Interface
REQ-001 The block SHALL have parameter AFULL_LEVEL, default 192, the RAM occupancy at or above which ALMOST_FULL is asserted (legal range 1..255).
REQ-002 PCLK  input  1  system clock; all state SHALL change on its rising edge only.
REQ-003 PRESETN  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 CLEAR  input  1  synchronous flush, active-high.
REQ-005 WR_VALID  input  1  push request.
REQ-006 WR_DATA  input  16  push data.
REQ-007 WR_READY  output  1  push accepted when WR_VALID and WR_READY are both high at a PCLK edge.
REQ-008 RD_VALID  output  1  RD_DATA holds the head entry.
REQ-009 RD_DATA  output  16  head entry.
REQ-010 RD_READY  input  1  pop when RD_VALID and RD_READY are both high at a PCLK edge.
REQ-011 COUNT  output  9  total entries held, RAM plus output stage, 0..258.
REQ-012 FULL, EMPTY, ALMOST_FULL  output  1 each  status flags.
REQ-013 RAM_WEN, RAM_REN  output  1 each  active-high write and read strobes to the 256x16 RAM wrapper.
REQ-014 RAM_WADDR, RAM_RADDR  output  8 each  RAM write and read addresses.
REQ-015 RAM_WD  output  16  RAM write data.
REQ-016 RAM_RD  input  16  RAM read data, valid in the cycle after the edge that samples RAM_REN high.

Function
REQ-017 Storage SHALL be one 256x16 RAM used as a circular buffer, plus a 2-entry registered output stage (skid) in front of RD_DATA.
REQ-018 WR_READY SHALL equal (RAM occupancy < 256) AND NOT CLEAR; FULL SHALL equal RAM occupancy == 256.
REQ-019 An accepted push SHALL drive RAM_WEN=1, RAM_WADDR=wptr and RAM_WD=WR_DATA combinationally in the same cycle; wptr SHALL increment mod 256 at that edge.
REQ-020 A RAM read SHALL be issued (RAM_REN=1, RAM_RADDR=rptr, rptr+1 mod 256) when RAM occupancy > 0 and (occupied output slots + in-flight reads − pop this cycle) <= 1.
REQ-021 RAM_RD SHALL be captured into the output stage at the edge ending the cycle after the read issue; at most one read SHALL be in flight per cycle.
REQ-022 RD_VALID SHALL be high whenever the head output slot is occupied; RD_DATA SHALL be stable while RD_VALID=1 and RD_READY=0.
REQ-023 With RD_READY held high and data available, sustained throughput SHALL be one entry per PCLK cycle.
REQ-024 First-word latency: a push at edge N into an empty block SHALL give RD_VALID=1 after edge N+2 (read issued in cycle N+1, captured at edge N+2).
REQ-025 Simultaneous push and pop SHALL both succeed; COUNT SHALL be unchanged.
REQ-026 A write and a read to the same RAM address in one cycle SHALL never occur; this is guaranteed by the occupancy rules in REQ-018 and REQ-020.
REQ-027 COUNT SHALL be +1 per accepted push and −1 per pop, saturating never (the legal range is guaranteed by design); EMPTY SHALL equal COUNT == 0.
REQ-028 ALMOST_FULL SHALL equal RAM occupancy >= AFULL_LEVEL.
REQ-029 Pointer wrap-around 255->0 SHALL be seamless, with no bubble and no data loss.
REQ-030 CLEAR SHALL reset pointers, counts and the output stage at the next edge; an in-flight read SHALL be discarded; CLEAR SHALL take priority over a simultaneous push or pop.
REQ-031 During CLEAR, RAM_WEN and RAM_REN SHALL be 0.

Reset
REQ-032 While PRESETN=0: wptr, rptr, RAM occupancy, COUNT, output stage and in-flight flag SHALL be 0; RD_VALID=0, WR_READY=0, EMPTY=1, FULL=0, ALMOST_FULL=0, RAM_WEN=0, RAM_REN=0, RD_DATA=0x0000.
REQ-033 WR_READY SHALL rise in the first cycle after PRESETN deasserts; RAM contents SHALL NOT be initialised by this block.
REQ-034 A reset asserted mid-operation SHALL discard all entries and any in-flight read immediately.

Verification
REQ-035 Push 0x1234 into an empty block with RD_READY=0 -> RD_VALID=1, RD_DATA=0x1234 two edges later; COUNT=1; EMPTY=0.
REQ-036 Push 256 words 0x0000..0x00FF with RD_READY=0 -> 2 words move to the output stage, so RAM holds 254; push 4 more -> FULL=1 and WR_READY=0 after the 258th; COUNT=258; ALMOST_FULL=1 from a RAM occupancy of 192.
REQ-037 Continuous push and pop for 600 words, WR_VALID=RD_READY=1 -> one word out per cycle after the initial latency; the data sequence is in order across two pointer wraps; COUNT is steady.
REQ-038 Random WR_VALID/RD_READY backpressure for 10k cycles against a reference queue model -> no loss, duplication or reorder; RD_DATA is stable while stalled.
REQ-039 Assert CLEAR in the same cycle as a read issue and a push -> the next cycle has COUNT=0, EMPTY=1 and RD_VALID=0; the subsequent push of 0xBEEF is the first word out.
REQ-040 Drop PRESETN asynchronously mid-stream -> all outputs take the REQ-032 values without waiting for a PCLK edge.
